// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI peripheral slice.
//   SPI_BYTE_W  : default serial word width in bits
//   SYNC_DEPTH  : number of flops in each pad synchronizer chain
// ---------------------------------------------------------------------------
package spi_pkg;
   localparam int SPI_BYTE_W = 8;
   localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync
// Multi-flop synchronizer for one asynchronous pad, with single-cycle
// rise/fall pulses derived from the synchronized value.
// Ports:
//   clk    : system clock
//   rst_n  : synchronous active-low reset (chain resets to RST_VAL)
//   d_in   : asynchronous pad input
//   d_sync : synchronized level
//   rise   : one-cycle pulse on synchronized 0->1
//   fall   : one-cycle pulse on synchronized 1->0
// ---------------------------------------------------------------------------
module spi_sync
   import spi_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic d_sync,
   output logic rise,
   output logic fall
);

   logic [SYNC_DEPTH-1:0] stage_q, stage_d;
   logic                  prev_q, prev_d;

   always_comb begin
      stage_d = {stage_q[SYNC_DEPTH-2:0], d_in};
      prev_d  = stage_q[SYNC_DEPTH-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q <= {SYNC_DEPTH{RST_VAL}};
         prev_q  <= RST_VAL;
      end else begin
         stage_q <= stage_d;
         prev_q  <= prev_d;
      end
   end

   // Edges compare the settled output against its own delayed copy so the
   // metastable first stage never feeds edge logic.
   assign d_sync = stage_q[SYNC_DEPTH-1];
   assign rise   = d_sync & ~prev_q;
   assign fall   = ~d_sync & prev_q;

endmodule

// File: rtl/spi_hardip_top.sv
// ---------------------------------------------------------------------------
// spi_hardip_top
// SPI mode-0 target (CPOL=0, CPHA=0, MSB first), oversampled by m_clk.
// Ports:
//   m_clk      : system clock (>= 4x sck)
//   rst_n      : synchronous active-low reset
//   sck_pad    : SPI clock from controller (async)
//   csn_pad    : chip select, active low (async)
//   mosi_pad   : serial data in (async)
//   miso_pad   : serial data out, 0 while deselected
//   DRDY       : received word valid, held until DWRITTEN
//   DWRITTEN   : consumer acknowledge of d_recieved
//   d_recieved : last complete received word
//   d_to_send  : word loaded for transmission
// ---------------------------------------------------------------------------
module spi_hardip_top
   import spi_pkg::*;
#(
   parameter int BYTE_W = SPI_BYTE_W
) (
   input  logic              m_clk,
   input  logic              rst_n,
   input  logic              sck_pad,
   input  logic              csn_pad,
   input  logic              mosi_pad,
   output logic              miso_pad,
   output logic              DRDY,
   input  logic              DWRITTEN,
   output logic [BYTE_W-1:0] d_recieved,
   input  logic [BYTE_W-1:0] d_to_send
);

   localparam int CNT_W = (BYTE_W > 2) ? $clog2(BYTE_W) : 1;
   localparam int SET_W = $clog2(SYNC_DEPTH + 1);

   logic sck_s, sck_rise, sck_fall;
   logic csn_s, csn_rise, csn_fall;
   logic mosi_s;

   logic [SYNC_DEPTH-1:0] mosi_stage_q, mosi_stage_d;
   logic [SET_W-1:0]      settle_q, settle_d;
   logic                  armed_q, armed_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [BYTE_W-1:0]     rx_q, rx_d;
   logic [BYTE_W-1:0]     tx_q, tx_d;
   logic [BYTE_W-1:0]     d_recieved_q, d_recieved_d;
   logic                  drdy_q, drdy_d;
   logic                  reload_q, reload_d;
   logic                  settle_done;
   logic [BYTE_W-1:0]     rx_next;

   spi_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clk    (m_clk),
      .rst_n  (rst_n),
      .d_in   (sck_pad),
      .d_sync (sck_s),
      .rise   (sck_rise),
      .fall   (sck_fall)
   );

   spi_sync #(.RST_VAL(1'b1)) u_csn_sync (
      .clk    (m_clk),
      .rst_n  (rst_n),
      .d_in   (csn_pad),
      .d_sync (csn_s),
      .rise   (csn_rise),
      .fall   (csn_fall)
   );

   assign mosi_s      = mosi_stage_q[SYNC_DEPTH-1];
   assign settle_done = (settle_q == SET_W'(SYNC_DEPTH));
   assign rx_next     = {rx_q[BYTE_W-2:0], mosi_s};

   always_comb begin
      mosi_stage_d = {mosi_stage_q[SYNC_DEPTH-2:0], mosi_pad};
      settle_d     = settle_done ? settle_q : settle_q + SET_W'(1);
      // Only accept a transfer once csn has been seen high after reset;
      // otherwise a csn held low through reset would look like a fresh
      // falling edge as the synchronizer fills.
      armed_d      = armed_q | (settle_done & csn_s);
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      d_recieved_d = d_recieved_q;
      drdy_d       = drdy_q;
      reload_d     = reload_q;

      // Acknowledge first so a completing word below overrides it.
      if (drdy_q && DWRITTEN) drdy_d = 1'b0;

      if (!armed_q || csn_s) begin
         // Deselected (or aborted mid-word): drop partial bits.
         bit_cnt_d = '0;
         rx_d      = '0;
         reload_d  = 1'b0;
      end else if (csn_fall) begin
         tx_d      = d_to_send;
         bit_cnt_d = '0;
         rx_d      = '0;
         reload_d  = 1'b0;
      end else begin
         if (sck_rise) begin
            rx_d = rx_next;
            if (bit_cnt_q == CNT_W'(BYTE_W - 1)) begin
               d_recieved_d = rx_next;
               drdy_d       = 1'b1;
               bit_cnt_d    = '0;
               reload_d     = 1'b1;
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
         if (sck_fall) begin
            // Falling edge after a completed word starts the next one.
            if (reload_q) begin
               tx_d     = d_to_send;
               reload_d = 1'b0;
            end else begin
               tx_d = {tx_q[BYTE_W-2:0], 1'b0};
            end
         end
      end
   end

   always_ff @(posedge m_clk) begin
      if (!rst_n) begin
         mosi_stage_q <= '0;
         settle_q     <= '0;
         armed_q      <= 1'b0;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         d_recieved_q <= '0;
         drdy_q       <= 1'b0;
         reload_q     <= 1'b0;
      end else begin
         mosi_stage_q <= mosi_stage_d;
         settle_q     <= settle_d;
         armed_q      <= armed_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         d_recieved_q <= d_recieved_d;
         drdy_q       <= drdy_d;
         reload_q     <= reload_d;
      end
   end

   assign miso_pad   = armed_q & ~csn_s & tx_q[BYTE_W-1];
   assign DRDY       = drdy_q;
   assign d_recieved = d_recieved_q;

endmodule

// File: tb/tb_spi_hardip_top.sv
// ---------------------------------------------------------------------------
// tb_spi_hardip_top
// Directed bench for spi_hardip_top: m_clk 100 MHz, sck 12.5 MHz (8x ratio).
// ---------------------------------------------------------------------------
module tb_spi_hardip_top;

   logic       m_clk = 1'b0;
   logic       rst_n;
   logic       sck_pad;
   logic       csn_pad;
   logic       mosi_pad;
   logic       miso_pad;
   logic       DRDY;
   logic       DWRITTEN;
   logic [7:0] d_recieved;
   logic [7:0] d_to_send;
   logic [7:0] dts_r;
   logic       lb;

   int n_chk  = 0;
   int n_fail = 0;
   int drdy_rises = 0;
   logic drdy_prev = 1'b0;

   logic [7:0] mi, mi2;
   logic       d3;
   int         r0;

   assign d_to_send = lb ? d_recieved : dts_r;

   always #5 m_clk = ~m_clk;

   spi_hardip_top #(.BYTE_W(8)) dut (
      .m_clk      (m_clk),
      .rst_n      (rst_n),
      .sck_pad    (sck_pad),
      .csn_pad    (csn_pad),
      .mosi_pad   (mosi_pad),
      .miso_pad   (miso_pad),
      .DRDY       (DRDY),
      .DWRITTEN   (DWRITTEN),
      .d_recieved (d_recieved),
      .d_to_send  (d_to_send)
   );

   always @(posedge m_clk) begin
      if (DRDY && !drdy_prev) drdy_rises++;
      drdy_prev <= DRDY;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Clock nbits of mo out MSB first; miso is sampled at each sck rise.
   // d3 is DRDY sampled 3 m_clk edges after the final rise. With coincide
   // set, DWRITTEN is high exactly at the completion edge.
   task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit coincide,
                           output logic [7:0] mi_o, output logic d3_o);
      mi_o = '0;
      d3_o = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi_pad = mo[7-i];
         #40;
         mi_o[7-i] = miso_pad;
         sck_pad = 1'b1;
         if (i == nbits - 1) begin
            repeat (2) @(posedge m_clk);
            #5;
            if (coincide) DWRITTEN = 1'b1;
            @(posedge m_clk);
            #1;
            d3_o = DRDY;
            DWRITTEN = 1'b0;
            #14;
         end else begin
            #40;
         end
         sck_pad = 1'b0;
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; sck_pad = 1'b0; csn_pad = 1'b1; mosi_pad = 1'b0;
      DWRITTEN = 1'b0; dts_r = 8'hFF; lb = 1'b0;

      // Reset
      repeat (3) @(posedge m_clk);
      #1;
      chk("rst_drdy", DRDY, 0);
      chk("rst_drec", d_recieved, 8'h00);
      chk("rst_miso", miso_pad, 0);
      @(negedge m_clk);
      rst_n = 1'b1;
      #100;
      chk("idle_miso", miso_pad, 0);

      // Receive 0xA5 while transmitting 0x3C
      dts_r = 8'h3C;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'hA5, 8, 1'b0, mi, d3);
      chk("a5_drdy3", d3, 1);
      chk("a5_drec", d_recieved, 8'hA5);
      chk("3c_miso", mi, 8'h3C);
      csn_pad = 1'b1;
      #80;

      // Completion with DWRITTEN coincident while DRDY already high
      dts_r = 8'h00;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'h5A, 8, 1'b1, mi, d3);
      chk("coin_drdy", d3, 1);
      chk("coin_drdy_after", DRDY, 1);
      chk("coin_drec", d_recieved, 8'h5A);

      // Overrun: next word with DRDY still high
      spi_xfer(8'hC3, 8, 1'b0, mi, d3);
      chk("ovr_drec", d_recieved, 8'hC3);
      chk("ovr_drdy", DRDY, 1);
      csn_pad = 1'b1;
      #80;

      // Acknowledge clears next cycle; acknowledge while low is ignored
      @(negedge m_clk);
      DWRITTEN = 1'b1;
      @(posedge m_clk);
      #1;
      chk("ack_clr", DRDY, 0);
      DWRITTEN = 1'b0;
      @(negedge m_clk);
      DWRITTEN = 1'b1;
      @(posedge m_clk);
      #1;
      DWRITTEN = 1'b0;
      repeat (2) @(posedge m_clk);
      #1;
      chk("ack_ign_drdy", DRDY, 0);
      chk("ack_ign_drec", d_recieved, 8'hC3);

      // Abort after 5 bits, then a full 0x81
      @(negedge m_clk);
      r0 = drdy_rises;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'hFF, 5, 1'b0, mi, d3);
      #20;
      csn_pad = 1'b1;
      #80;
      chk("abort_drdy", DRDY, 0);
      chk("abort_drec", d_recieved, 8'hC3);
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'h81, 8, 1'b0, mi, d3);
      chk("x81_drec", d_recieved, 8'h81);
      chk("x81_drdy3", d3, 1);
      chk("x81_rises", drdy_rises - r0, 1);
      csn_pad = 1'b1;
      #80;

      // Loopback, two back-to-back words of all ones
      lb = 1'b1;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'hFF, 8, 1'b0, mi, d3);
      chk("lb1_drec", d_recieved, 8'hFF);
      chk("lb1_miso", mi, 8'h81);
      spi_xfer(8'hFF, 8, 1'b0, mi2, d3);
      chk("lb2_drec", d_recieved, 8'hFF);
      chk("lb2_miso", mi2, 8'hFF);
      csn_pad = 1'b1;
      #80;
      lb = 1'b0;

      // Reset mid-word with csn held low: no reception until a fresh csn fall
      dts_r = 8'h00;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'hE0, 3, 1'b0, mi, d3);
      @(negedge m_clk);
      rst_n = 1'b0;
      repeat (3) @(posedge m_clk);
      #1;
      chk("mrst_drdy", DRDY, 0);
      chk("mrst_drec", d_recieved, 8'h00);
      chk("mrst_miso", miso_pad, 0);
      @(negedge m_clk);
      rst_n = 1'b1;
      #60;
      spi_xfer(8'h77, 8, 1'b0, mi, d3);
      #40;
      chk("mrst_nofall_drdy", DRDY, 0);
      chk("mrst_nofall_drec", d_recieved, 8'h00);
      csn_pad = 1'b1;
      #80;
      csn_pad = 1'b0;
      #60;
      spi_xfer(8'h66, 8, 1'b0, mi, d3);
      chk("mrst_fresh_drec", d_recieved, 8'h66);
      chk("mrst_fresh_drdy", d3, 1);
      csn_pad = 1'b1;
      #80;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
